// File: rtl/vlg_cnt_pkg.sv
// vlg_cnt_pkg: shared constants for the multi-channel counter.
// Holds overflow-mode selectors and per-channel operation priority.
package vlg_cnt_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_COUNT = 2'd1,
      OP_LOAD  = 2'd2,
      OP_CLR   = 2'd3
   } op_e;

   // clear beats load beats count beats hold
   function automatic op_e op_sel(
      input logic clr,
      input logic load,
      input logic en
   );
      op_e op;
      priority case (1'b1)
         clr:     op = OP_CLR;
         load:    op = OP_LOAD;
         en:      op = OP_COUNT;
         default: op = OP_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/vlg_cnt_ch.sv
// vlg_cnt_ch: one up/down counter channel with clear, load and
// wrap or saturate overflow handling plus a terminal-count flag.
module vlg_cnt_ch
   import vlg_cnt_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MODE  = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             tc_next
);

   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   op_e              op;
   logic             at_lim;
   logic [WIDTH-1:0] stepped;
   logic [WIDTH-1:0] cnt_next;

   // decode operation and precompute the one-step neighbour
   always_comb begin
      op      = op_sel(clr, load, en);
      at_lim  = dir ? (cnt == MAX) : (cnt == '0);
      stepped = dir ? (cnt + ONE) : (cnt - ONE);
   end

   // next count and next terminal flag
   always_comb begin
      cnt_next = cnt;
      tc_next  = tc;
      unique case (op)
         OP_CLR: begin
            cnt_next = '0;
            tc_next  = 1'b0;
         end
         OP_LOAD: begin
            cnt_next = load_val;
            tc_next  = 1'b0;
         end
         OP_COUNT: begin
            if (MODE == MODE_SAT) begin
               // flag stays up while pinned at the limit we head to
               cnt_next = at_lim ? cnt : stepped;
               tc_next  = dir ? (cnt_next == MAX)
                              : (cnt_next == '0);
            end else begin
               // flag marks the cycle the wrapped value shows
               cnt_next = stepped;
               tc_next  = at_lim;
            end
         end
         default: begin
            if (MODE != MODE_SAT) tc_next = 1'b0;
         end
      endcase
   end

   // count and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         tc  <= 1'b0;
      end else begin
         cnt <= cnt_next;
         tc  <= tc_next;
      end
   end

endmodule

// File: rtl/vlg_multi_cnt.sv
// vlg_multi_cnt: CH independent counter channels with packed I/O
// and a registered any-terminal-count summary flag.
module vlg_multi_cnt
   import vlg_cnt_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CH    = 2,
   parameter int MODE  = MODE_WRAP
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [CH-1:0]       i_en,
   input  logic [CH-1:0]       i_dir,
   input  logic [CH-1:0]       i_clr,
   input  logic [CH-1:0]       i_load,
   input  logic [CH*WIDTH-1:0] i_load_val,
   output logic [CH*WIDTH-1:0] o_cnt,
   output logic [CH-1:0]       o_tc,
   output logic                o_any_tc
);

   logic [CH-1:0] tc_next;

   for (genvar k = 0; k < CH; k++) begin : g_ch
      vlg_cnt_ch #(
         .WIDTH (WIDTH),
         .MODE  (MODE)
      ) u_ch (
         .clk      (i_clk),
         .rst_n    (i_rst_n),
         .en       (i_en[k]),
         .dir      (i_dir[k]),
         .clr      (i_clr[k]),
         .load     (i_load[k]),
         .load_val (i_load_val[k*WIDTH +: WIDTH]),
         .cnt      (o_cnt[k*WIDTH +: WIDTH]),
         .tc       (o_tc[k]),
         .tc_next  (tc_next[k])
      );
   end

   // summary flag from next-state flags so it lines up with o_tc
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_any_tc <= 1'b0;
      else          o_any_tc <= |tc_next;
   end

endmodule
